// File: rtl/video_sync_vg.sv
// Free-running raster timing generator: hsync, vsync, data-enable and active pixel coordinates.
// Optional macro SYNC_ACTIVE_LOW_EN makes hs_out/vs_out active-low.
module video_sync_vg #(
  parameter int unsigned X_BITS  = 11,
  parameter int unsigned Y_BITS  = 11,
  parameter int unsigned H_TOTAL = 1344,
  parameter int unsigned H_SYNC  = 32,
  parameter int unsigned H_BP    = 120,
  parameter int unsigned H_ACT   = 1024,
  parameter int unsigned H_FP    = 168,
  parameter int unsigned V_TOTAL = 635,
  parameter int unsigned V_SYNC  = 6,
  parameter int unsigned V_BP    = 14,
  parameter int unsigned V_ACT   = 600,
  parameter int unsigned V_FP    = 15
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              hs_out,
  output logic              vs_out,
  output logic              de_out,
  output logic [X_BITS-1:0] x_act,
  output logic [Y_BITS-1:0] y_act
);

  localparam int unsigned CNT_RAW = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 1;
  localparam int unsigned CNT_W   = (CNT_RAW < 12) ? 12 : CNT_RAW;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_DE_BEG   = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_DE_END   = CNT_W'(H_SYNC + H_BP + H_ACT);
  localparam logic [CNT_W-1:0] V_DE_BEG   = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_DE_END   = CNT_W'(V_SYNC + V_BP + V_ACT);

  // Idle level of the sync outputs; XOR-ed onto the raw active-high decode.
`ifdef SYNC_ACTIVE_LOW_EN
  localparam logic SYNC_IDLE = 1'b1;
`else
  localparam logic SYNC_IDLE = 1'b0;
`endif

  logic [CNT_W-1:0]  h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]  v_cnt_q, v_cnt_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              de_q, de_d;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic              h_de, v_de;

  // Raster counters and region decode; outputs are the registered decode.
  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
    end

    h_de = (h_cnt_q >= H_DE_BEG) && (h_cnt_q < H_DE_END);
    v_de = (v_cnt_q >= V_DE_BEG) && (v_cnt_q < V_DE_END);
    hs_d = (h_cnt_q < H_SYNC_END) ^ SYNC_IDLE;
    vs_d = (v_cnt_q < V_SYNC_END) ^ SYNC_IDLE;
    de_d = h_de && v_de;
    x_d  = '0;
    y_d  = '0;
    if (de_d) begin
      x_d = X_BITS'(h_cnt_q - H_DE_BEG);
      y_d = Y_BITS'(v_cnt_q - V_DE_BEG);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hs_q    <= SYNC_IDLE;
      vs_q    <= SYNC_IDLE;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign hs_out = hs_q;
  assign vs_out = vs_q;
  assign de_out = de_q;
  assign x_act  = x_q;
  assign y_act  = y_q;

endmodule

// File: tb/tb_video_sync_vg.sv
// Bench for video_sync_vg: default-size instance checked at table checkpoints, and a
// shrunken-raster instance checked every cycle against a scoreboard over many frames.
module tb_video_sync_vg;

`ifdef SYNC_ACTIVE_LOW_EN
  localparam logic POL = 1'b1;
`else
  localparam logic POL = 1'b0;
`endif

  // Small raster: 20 clks/line, 12 lines/frame, 240 clks/frame.
  localparam int SH_SYNC = 4, SH_BP = 3, SH_ACT = 8, SH_FP = 5, SH_TOT = 20;
  localparam int SV_SYNC = 2, SV_BP = 3, SV_ACT = 5, SV_FP = 2, SV_TOT = 12;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        hs_d, vs_d, de_d;
  logic [10:0] x_d, y_d;
  logic        hs_s, vs_s, de_s;
  logic [3:0]  x_s;
  logic [2:0]  y_s;

  video_sync_vg dut_def (
    .clk(clk), .rstn(rstn), .hs_out(hs_d), .vs_out(vs_d), .de_out(de_d),
    .x_act(x_d), .y_act(y_d)
  );

  video_sync_vg #(
    .X_BITS(4), .Y_BITS(3),
    .H_TOTAL(SH_TOT), .H_SYNC(SH_SYNC), .H_BP(SH_BP), .H_ACT(SH_ACT), .H_FP(SH_FP),
    .V_TOTAL(SV_TOT), .V_SYNC(SV_SYNC), .V_BP(SV_BP), .V_ACT(SV_ACT), .V_FP(SV_FP)
  ) dut_sm (
    .clk(clk), .rstn(rstn), .hs_out(hs_s), .vs_out(vs_s), .de_out(de_s),
    .x_act(x_s), .y_act(y_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard for the small instance: expectation pushed at each edge, popped at negedge.
  typedef struct packed {
    logic       hs, vs, de;
    logic [3:0] x;
    logic [2:0] y;
  } sm_exp_t;
  sm_exp_t sb_q[$];

  initial begin
    int mh = 0, mv = 0;
    sm_exp_t e;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        e = '{hs: POL, vs: POL, de: 1'b0, x: 4'd0, y: 3'd0};
        mh = 0;
        mv = 0;
      end else begin
        e.hs = (mh < SH_SYNC) ^ POL;
        e.vs = (mv < SV_SYNC) ^ POL;
        e.de = (mh >= SH_SYNC + SH_BP) && (mh < SH_SYNC + SH_BP + SH_ACT) &&
               (mv >= SV_SYNC + SV_BP) && (mv < SV_SYNC + SV_BP + SV_ACT);
        e.x  = e.de ? 4'(mh - SH_SYNC - SH_BP) : 4'd0;
        e.y  = e.de ? 3'(mv - SV_SYNC - SV_BP) : 3'd0;
        mh++;
        if (mh == SH_TOT) begin
          mh = 0;
          mv = (mv == SV_TOT - 1) ? 0 : mv + 1;
        end
      end
      sb_q.push_back(e);
    end
  end

  initial begin
    sm_exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sm_hs", 32'(hs_s), 32'(e.hs));
        chk("sm_vs", 32'(vs_s), 32'(e.vs));
        chk("sm_de", 32'(de_s), 32'(e.de));
        chk("sm_x",  32'(x_s),  32'(e.x));
        chk("sm_y",  32'(y_s),  32'(e.y));
      end
    end
  end

  // Default-raster checkpoints: n = edges since reset release, sampled just after edge n.
  typedef struct {
    int unsigned n;
    logic        hs, vs, de;
    logic [10:0] x, y;
  } vec_t;
  vec_t tbl[13];

  task automatic run_table(input string tag);
    int unsigned cur = 0;
    for (int i = 0; i < 13; i++) begin
      repeat (tbl[i].n - cur) @(posedge clk);
      cur = tbl[i].n;
      #1;
      chk({tag, "_hs"}, 32'(hs_d), 32'(tbl[i].hs ^ POL));
      chk({tag, "_vs"}, 32'(vs_d), 32'(tbl[i].vs ^ POL));
      chk({tag, "_de"}, 32'(de_d), 32'(tbl[i].de));
      chk({tag, "_x"},  32'(x_d),  32'(tbl[i].x));
      chk({tag, "_y"},  32'(y_d),  32'(tbl[i].y));
    end
  endtask

  task automatic chk_def_reset(input string tag);
    chk({tag, "_hs"}, 32'(hs_d), 32'(POL));
    chk({tag, "_vs"}, 32'(vs_d), 32'(POL));
    chk({tag, "_de"}, 32'(de_d), 32'd0);
    chk({tag, "_x"},  32'(x_d),  32'd0);
    chk({tag, "_y"},  32'(y_d),  32'd0);
  endtask

  initial begin
    logic found, prev, cur;
    int   hi, per;

    tbl[0]  = '{1,     1'b1, 1'b1, 1'b0, 11'd0,    11'd0};
    tbl[1]  = '{32,    1'b1, 1'b1, 1'b0, 11'd0,    11'd0};
    tbl[2]  = '{33,    1'b0, 1'b1, 1'b0, 11'd0,    11'd0};
    tbl[3]  = '{1345,  1'b1, 1'b1, 1'b0, 11'd0,    11'd0};
    tbl[4]  = '{8064,  1'b0, 1'b1, 1'b0, 11'd0,    11'd0};
    tbl[5]  = '{8065,  1'b1, 1'b0, 1'b0, 11'd0,    11'd0};
    tbl[6]  = '{27032, 1'b0, 1'b0, 1'b0, 11'd0,    11'd0};
    tbl[7]  = '{27033, 1'b0, 1'b0, 1'b1, 11'd0,    11'd0};
    tbl[8]  = '{27034, 1'b0, 1'b0, 1'b1, 11'd1,    11'd0};
    tbl[9]  = '{28056, 1'b0, 1'b0, 1'b1, 11'd1023, 11'd0};
    tbl[10] = '{28057, 1'b0, 1'b0, 1'b0, 11'd0,    11'd0};
    tbl[11] = '{28377, 1'b0, 1'b0, 1'b1, 11'd0,    11'd1};
    tbl[12] = '{28500, 1'b0, 1'b0, 1'b1, 11'd123,  11'd1};

    rstn = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_def_reset("rst");
    rstn = 1'b1;
    run_table("run1");

    // One-cycle reset in the middle of a line, then the raster must restart identically.
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk_def_reset("midrst");
    rstn = 1'b1;
    run_table("run2");

    // Small raster: vsync high width and rising-edge period.
    found = 1'b0;
    prev  = vs_s ^ POL;
    for (int i = 0; i < 600 && !found; i++) begin
      @(posedge clk);
      #1;
      cur = vs_s ^ POL;
      if (cur && !prev) found = 1'b1;
      prev = cur;
    end
    chk("sm_vs_rise_seen", 32'(found), 32'd1);
    hi = 1;
    per = 0;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(posedge clk);
      #1;
      per++;
      cur = vs_s ^ POL;
      if (cur && !prev) found = 1'b1;
      else if (cur) hi++;
      prev = cur;
    end
    chk("sm_vs_high_len", 32'(hi), 32'(SV_SYNC * SH_TOT));
    chk("sm_vs_period", 32'(per), 32'(SV_TOT * SH_TOT));

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
